// File: rtl/crossy_pkg.sv
// Shared constants for the crossy-road game: FSM state encoding and palette.
package crossy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  // 8-bit RRRGGGBB palette; the hit flash reuses the chicken's yellow
  localparam logic [7:0] COL_BLACK  = 8'h00;
  localparam logic [7:0] COL_WHITE  = 8'hFF;
  localparam logic [7:0] COL_GREEN  = 8'h1C;
  localparam logic [7:0] COL_RED    = 8'hE0;
  localparam logic [7:0] COL_YELLOW = 8'hFC;
  localparam logic [7:0] COL_FLASH  = COL_YELLOW;

  function automatic logic beats_high(input logic [7:0] score_v, input logic [7:0] high_v);
    return score_v > high_v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

  logic            sync0_q, sync1_q;
  logic            level_q, level_d, level_prev_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = {DB_W{1'b0}};
    if (sync1_q == level_q) begin
      cnt_d = {DB_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = {DB_W{1'b0}};
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= {DB_W{1'b0}};
      press_q      <= 1'b0;
    end else begin
      sync0_q      <= btn_i;
      sync1_q      <= sync0_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow sequencer: gated move pulses, per-frame collision decision,
// hit-flash / game-over sequence, datapath reset and high score.
module game_ctrl
  import crossy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18,
  parameter int unsigned HIT_FRAMES      = 60,
  parameter int unsigned FLASH_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_btn,
  input  logic       frame_start,
  input  logic       collision,
  input  logic [7:0] score,
  output logic       move_pulse,
  output logic       game_rst,
  output logic [1:0] state,
  output logic       flash,
  output logic [7:0] high_score
);

  localparam int unsigned CW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  game_state_e   state_q;
  logic          move_pulse_q, game_rst_q, flash_q, latch_q;
  logic [7:0]    high_q;
  logic [CW-1:0] hit_cnt_q;

  logic          press_s, hit_now_s, hit_last_s, flash_tick_s;
  logic [31:0]   cnt_inc_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (move_btn),
    .press_o (press_s)
  );

  // A collision in the frame_start cycle still belongs to the ending frame
  assign hit_now_s    = frame_start & (latch_q | collision);
  assign cnt_inc_s    = 32'(hit_cnt_q) + 32'd1;
  assign hit_last_s   = (32'(hit_cnt_q) == (HIT_FRAMES - 32'd1));
  assign flash_tick_s = ((cnt_inc_s % FLASH_FRAMES) == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      move_pulse_q <= 1'b0;
      game_rst_q   <= 1'b1;
      flash_q      <= 1'b0;
      latch_q      <= 1'b0;
      high_q       <= 8'd0;
      hit_cnt_q    <= {CW{1'b0}};
    end else begin
      move_pulse_q <= 1'b0;
      game_rst_q   <= 1'b0;
      latch_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press_s) state_q <= ST_PLAY;
          else         state_q <= ST_IDLE;
        end
        ST_PLAY: begin
          move_pulse_q <= press_s & ~hit_now_s;
          if (hit_now_s) begin
            state_q   <= ST_HIT;
            hit_cnt_q <= {CW{1'b0}};
            flash_q   <= 1'b1;
            if (beats_high(score, high_q)) high_q <= score;
            else                           high_q <= high_q;
          end else if (frame_start) begin
            latch_q <= 1'b0;
          end else begin
            latch_q <= latch_q | collision;
          end
        end
        ST_HIT: begin
          if (frame_start) begin
            if (hit_last_s) begin
              state_q   <= ST_OVER;
              flash_q   <= 1'b0;
              hit_cnt_q <= {CW{1'b0}};
            end else begin
              hit_cnt_q <= hit_cnt_q + CW'(1);
              if (flash_tick_s) flash_q <= ~flash_q;
              else              flash_q <= flash_q;
            end
          end else begin
            state_q <= ST_HIT;
          end
        end
        ST_OVER: begin
          if (press_s) begin
            state_q    <= ST_IDLE;
            game_rst_q <= 1'b1;
          end else begin
            state_q <= ST_OVER;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign move_pulse = move_pulse_q;
  assign game_rst   = game_rst_q;
  assign state      = state_q;
  assign flash      = flash_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short debounce and hit timing.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, move_btn, frame_start, collision;
  logic [7:0] score;
  logic       move_pulse, game_rst, flash;
  logic [1:0] state;
  logic [7:0] high_score;

  int n_total = 0;
  int n_pass  = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DB_W            (3),
    .HIT_FRAMES      (3),
    .FLASH_FRAMES    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .move_btn    (move_btn),
    .frame_start (frame_start),
    .collision   (collision),
    .score       (score),
    .move_pulse  (move_pulse),
    .game_rst    (game_rst),
    .state       (state),
    .flash       (flash),
    .high_score  (high_score)
  );

  always @(negedge clk) if (move_pulse) pulse_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    repeat (19) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clean_press();
    move_btn = 1'b1;
    repeat (8) tick();
    move_btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; move_btn = 1'b0; frame_start = 1'b0; collision = 1'b0; score = 8'd0;
    repeat (3) tick();
    check("rst_game_rst", 32'(game_rst), 1);
    check("rst_state", 32'(state), 0);
    reset = 1'b0;
    check("post_rst_game_rst_hi", 32'(game_rst), 1);
    tick();
    check("post_rst_game_rst_lo", 32'(game_rst), 0);
    check("post_rst_state", 32'(state), 0);
    check("post_rst_high", 32'(high_score), 0);
    check("post_rst_flash", 32'(flash), 0);

    // bouncing input, then a stable hold
    for (int i = 0; i < 10; i++) begin
      move_btn = ((i / 2) % 2 == 1);
      tick();
    end
    check("bounce_state", 32'(state), 0);
    move_btn = 1'b1;
    repeat (7) tick();
    check("idle_press_not_yet", 32'(state), 0);
    tick();
    check("idle_press_play", 32'(state), 1);
    check("idle_press_no_pulse", 32'(move_pulse), 0);
    move_btn = 1'b0;
    repeat (10) tick();
    check("idle_pulse_count", pulse_cnt, 0);

    // clean press in PLAY
    move_btn = 1'b1;
    repeat (7) tick();
    check("play_pulse_pre", 32'(move_pulse), 0);
    tick();
    check("play_pulse_hi", 32'(move_pulse), 1);
    tick();
    check("play_pulse_lo", 32'(move_pulse), 0);
    move_btn = 1'b0;
    repeat (10) tick();
    check("play_pulse_count", pulse_cnt, 1);
    check("play_state", 32'(state), 1);

    // mid-frame collision latched until frame_start
    score = 8'd5;
    repeat (5) tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    repeat (5) tick();
    check("latch_still_play", 32'(state), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("hit_state", 32'(state), 2);
    check("hit_flash", 32'(flash), 1);
    check("hit_high5", 32'(high_score), 5);

    // hit sequence with a press that must be ignored
    move_btn = 1'b1;
    frame();
    check("hit_f1_state", 32'(state), 2);
    check("hit_f1_flash", 32'(flash), 0);
    move_btn = 1'b0;
    frame();
    check("hit_f2_state", 32'(state), 2);
    check("hit_f2_flash", 32'(flash), 1);
    frame();
    check("hit_f3_over", 32'(state), 3);
    check("hit_f3_flash", 32'(flash), 0);
    check("hit_press_ignored", pulse_cnt, 1);
    frame();
    check("over_frame_noeffect", 32'(state), 3);

    // restart from OVER
    move_btn = 1'b1;
    repeat (7) tick();
    check("over_wait_state", 32'(state), 3);
    check("over_wait_rst", 32'(game_rst), 0);
    tick();
    check("restart_state", 32'(state), 0);
    check("restart_rst_hi", 32'(game_rst), 1);
    tick();
    check("restart_rst_lo", 32'(game_rst), 0);
    move_btn = 1'b0;
    repeat (10) tick();

    // second game: lower score keeps high score
    clean_press();
    check("g2_play", 32'(state), 1);
    score = 8'd3;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    frame();
    check("g2_hit", 32'(state), 2);
    check("g2_high_kept", 32'(high_score), 5);
    repeat (3) frame();
    check("g2_over", 32'(state), 3);
    clean_press();
    check("g3_idle", 32'(state), 0);
    clean_press();
    check("g3_play", 32'(state), 1);
    check("g3_no_pulse", pulse_cnt, 1);

    // collision only in the frame_start cycle, higher score
    score = 8'd9;
    repeat (3) tick();
    collision = 1'b1;
    frame_start = 1'b1;
    tick();
    collision = 1'b0;
    frame_start = 1'b0;
    check("fs_coll_hit", 32'(state), 2);
    check("fs_coll_high9", 32'(high_score), 9);
    check("fs_coll_flash", 32'(flash), 1);

    // reset in HIT
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("midrst_state", 32'(state), 0);
    check("midrst_flash", 32'(flash), 0);
    check("midrst_high", 32'(high_score), 0);
    check("midrst_game_rst", 32'(game_rst), 1);
    reset = 1'b0;
    tick();
    check("midrst_game_rst_lo", 32'(game_rst), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
